// File: rtl/b2a_pkg.sv
// b2a_pkg: scheduler state, in-flight tag type and core parameter derivations.
package b2a_pkg;
    localparam int K_WIDTH_DEF  = 32;
    localparam int N_SHARES_DEF = 3;
    localparam int RANDNUM_DEF  = 201;
    localparam int NREQ         = 2;
    localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    // CSA tree depth (n-2) plus two Kogge-Stone adders of log2(k)+1 stages each
    function automatic int f_lat(input int k, input int n);
        return (n - 2) + 2 * ($clog2(k) + 1);
    endfunction

    function automatic int f_rnd_w(input int k, input int randnum);
        return randnum * k;
    endfunction
endpackage

// File: rtl/b2a_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the search starts one past the last winner.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_adv,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_id
);
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IDW'(NREQ - 1);
        end else if (i_adv) begin
            r_last <= o_id;
        end
    end

    // Walk from farthest to nearest so the nearest requester wins
    always_comb begin
        o_gnt = '0;
        o_id  = r_last;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (i_req[w_idx]) begin
                o_gnt = NREQ'(1) << w_idx;
                o_id  = w_idx;
            end
        end
    end
endmodule

// File: rtl/b2a_sched.sv
// b2a_sched: round-robin sharing of one pipelined SecB2A core among NREQ requesters.
// Define B2A_SCHED_LATCHK_EN to add the sticky core-latency mismatch check on o_err.
module b2a_sched
    import b2a_pkg::*;
#(
    parameter int K_WIDTH  = K_WIDTH_DEF,
    parameter int N_SHARES = N_SHARES_DEF,
    parameter int LAT      = f_lat(K_WIDTH, N_SHARES),
    parameter int RND_W    = f_rnd_w(K_WIDTH, RANDNUM_DEF),
    localparam int MASKW   = K_WIDTH * N_SHARES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_drain,
    output logic                  o_drained,
    output logic                  o_busy,
    input  logic [NREQ-1:0]       i_req_vld,
    output logic [NREQ-1:0]       o_req_rdy,
    input  logic [NREQ*MASKW-1:0] i_req_b,
    input  logic                  i_rnd_vld,
    output logic                  o_rnd_rdy,
    input  logic [RND_W-1:0]      i_rnd_in,
    output logic                  o_core_dvld,
    output logic                  o_core_ena,
    output logic [RND_W-1:0]      o_core_rnd,
    output logic [MASKW-1:0]      o_core_i_b,
    input  logic [MASKW-1:0]      i_core_o_a,
    input  logic                  i_core_ovld,
    output logic [NREQ-1:0]       o_res_vld,
    output logic [MASKW-1:0]      o_res_a,
    output logic                  o_err
);
    state_t            r_state, w_state_nxt;
    tag_t              r_tag [0:LAT];
    logic              r_core_dvld, r_drained;
    logic [MASKW-1:0]  r_core_i_b, r_res_a;
    logic [RND_W-1:0]  r_core_rnd;
    logic [NREQ-1:0]   r_res_vld, w_gnt;
    logic [IDW-1:0]    w_id;
    logic              w_issue, w_pipe_busy;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (i_req_vld),
        .i_adv (w_issue),
        .o_gnt (w_gnt),
        .o_id  (w_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN only ever exits to IDLE, so a new job always passes through IDLE first
    always_comb begin
        w_state_nxt = (r_state == ST_IDLE) ? (i_en ? ST_RUN : ST_IDLE) :
                      (r_state == ST_RUN)  ? ((i_drain || !i_en) ? ST_DRAIN : ST_RUN) :
                      (w_pipe_busy ? ST_DRAIN : ST_IDLE);
    end

    always_comb begin
        w_issue   = (r_state == ST_RUN) && i_rnd_vld && (|i_req_vld);
        o_req_rdy = w_issue ? w_gnt : '0;
        o_rnd_rdy = w_issue;
        o_core_ena = r_state != ST_IDLE;
        o_busy    = (r_state != ST_IDLE) || w_pipe_busy;
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i <= LAT; i++) w_pipe_busy = w_pipe_busy | r_tag[i].valid;
    end

    // Shares and randomness live for exactly one cycle; idle cycles present zeros to the core
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_dvld <= 1'b0;
            r_core_i_b  <= '0;
            r_core_rnd  <= '0;
            r_tag       <= '{default: '0};
            r_res_vld   <= '0;
            r_res_a     <= '0;
            r_drained   <= 1'b0;
        end else begin
            r_core_dvld <= w_issue;
            r_core_i_b  <= w_issue ? i_req_b[w_id*MASKW +: MASKW] : '0;
            r_core_rnd  <= w_issue ? i_rnd_in : '0;
            r_tag[0]    <= w_issue ? {1'b1, w_id} : '0;
            for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
            r_res_vld   <= r_tag[LAT].valid ? (NREQ'(1) << r_tag[LAT].id) : '0;
            r_res_a     <= r_tag[LAT].valid ? i_core_o_a : '0;
            r_drained   <= (r_state == ST_DRAIN) && !w_pipe_busy;
        end
    end

    assign o_core_dvld = r_core_dvld;
    assign o_core_i_b  = r_core_i_b;
    assign o_core_rnd  = r_core_rnd;
    assign o_res_vld   = r_res_vld;
    assign o_res_a     = r_res_a;
    assign o_drained   = r_drained;

`ifdef B2A_SCHED_LATCHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_core_ovld != r_tag[LAT].valid) begin
            r_err <= 1'b1;
            $error("b2a_sched: core_ovld disagrees with tag pipe tail");
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_ovld;

    assign w_unused_ovld = i_core_ovld;
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_b2a_sched.sv
// tb_b2a_sched: table vectors, directed corner sequences and random traffic against a
// cycle-schedule reference model, with a behavioural SecB2A stand-in of latency LAT.
module tb_b2a_sched;
    import b2a_pkg::*;

    localparam int KW = 32;
    localparam int NS = 3;
    localparam int MW = KW * NS;
    localparam int NR = 2;
    localparam int LATC = 13;
    localparam int RW = 6432;
    localparam int NC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, drain = 1'b0, rnd_vld = 1'b0;
    logic [NR-1:0] req_vld = '0;
    logic [NR*MW-1:0] req_b = '0;
    logic [RW-1:0] rnd_in = '0;
    logic [KW-1:0] rnd_word;
    logic drained, busy, rnd_rdy, core_dvld, core_ena, core_ovld, err;
    logic [NR-1:0] req_rdy, res_vld;
    logic [RW-1:0] core_rnd;
    logic [MW-1:0] core_i_b, core_o_a, res_a;

    always #5 clk = ~clk;

    b2a_sched dut (
        .clk(clk), .rst(rst), .i_en(en), .i_drain(drain), .o_drained(drained), .o_busy(busy),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_b(req_b),
        .i_rnd_vld(rnd_vld), .o_rnd_rdy(rnd_rdy), .i_rnd_in(rnd_in),
        .o_core_dvld(core_dvld), .o_core_ena(core_ena), .o_core_rnd(core_rnd),
        .o_core_i_b(core_i_b), .i_core_o_a(core_o_a), .i_core_ovld(core_ovld),
        .o_res_vld(res_vld), .o_res_a(res_a), .o_err(err)
    );

    function automatic logic [KW-1:0] bxor(input logic [MW-1:0] s);
        return s[0 +: KW] ^ s[KW +: KW] ^ s[2*KW +: KW];
    endfunction

    function automatic logic [KW-1:0] asum(input logic [MW-1:0] s);
        return s[0 +: KW] + s[KW +: KW] + s[2*KW +: KW];
    endfunction

    function automatic logic [MW-1:0] to_arith(input logic [MW-1:0] b);
        logic [KW-1:0] a0, a1;
        a0 = $urandom;
        a1 = $urandom;
        return {bxor(b) - a0 - a1, a1, a0};
    endfunction

    // SecB2A stand-in: fresh arithmetic masking of the Boolean input, LATC cycles later
    logic [LATC-1:0] fc_v = '0;
    logic [MW-1:0] fc_a [LATC];
    bit early = 1'b0;

    always @(posedge clk) begin
        fc_v <= rst ? '0 : {fc_v[LATC-2:0], core_dvld};
        fc_a[0] <= to_arith(core_i_b);
        for (int i = 1; i < LATC; i++) fc_a[i] <= fc_a[i-1];
    end

    assign core_ovld = early ? fc_v[LATC-2] : fc_v[LATC-1];
    assign core_o_a  = early ? fc_a[LATC-2] : fc_a[LATC-1];

    // Reference model: state, last winner and a per-cycle schedule of expected results
    int cyc_n = 0;
    bit chk = 1'b0;
    int m_st = 0;
    int m_last = NR - 1;
    bit m_drained = 1'b0, p_dvld = 1'b0;
    logic [MW-1:0] p_b = '0;
    logic [RW-1:0] p_rnd = '0;
    bit ev [NC];
    int eid [NC];
    logic [KW-1:0] ex [NC];
    int n_vec = 0, n_err = 0;

    logic [NR-1:0] obs_rdy, obs_res;
    logic [KW-1:0] obs_sum;
    logic obs_rnd_rdy, obs_busy, obs_drained, obs_err, obs_any;

    typedef struct {
        logic [NR-1:0] rv;
        logic          rn;
        logic [NR-1:0] exp_rdy;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic int winner(input logic [NR-1:0] rv, input int last);
        for (int k = 1; k <= NR; k++)
            if (((int'(rv) >> ((last + k) % NR)) & 1) != 0) return (last + k) % NR;
        return -1;
    endfunction

    task automatic cyc();
        int w;
        bit pipe;
        @(negedge clk);
        w = (m_st == 1 && rnd_vld) ? winner(req_vld, m_last) : -1;
        pipe = 1'b0;
        for (int c = cyc_n + 1; c <= cyc_n + LATC + 1; c++) if (ev[c]) pipe = 1'b1;
        obs_rdy = req_rdy;
        obs_res = res_vld;
        obs_sum = asum(res_a);
        obs_rnd_rdy = rnd_rdy;
        obs_busy = busy;
        obs_drained = drained;
        obs_err = err;
        obs_any = |{drained, busy, req_rdy, rnd_rdy, core_dvld, core_ena, core_rnd, core_i_b, res_vld, res_a, err};
        if (chk) begin
            check("req_rdy", 128'(req_rdy), (w < 0) ? 128'(0) : (128'(1) << w));
            check("rnd_rdy", 128'(rnd_rdy), 128'(w >= 0));
            check("core_ena", 128'(core_ena), 128'(m_st != 0));
            check("busy", 128'(busy), 128'(m_st != 0 || pipe));
            check("drained", 128'(drained), 128'(m_drained));
            check("core_dvld", 128'(core_dvld), 128'(p_dvld));
            check("core_i_b", 128'(core_i_b), 128'(p_b));
            check("core_rnd_lo", 128'(core_rnd[KW-1:0]), 128'(p_rnd[KW-1:0]));
            check("core_rnd_eq", 128'(core_rnd == p_rnd), 128'(1));
            check("res_vld", 128'(res_vld), ev[cyc_n] ? (128'(1) << eid[cyc_n]) : 128'(0));
            check("res_a", ev[cyc_n] ? 128'(obs_sum) : 128'(res_a), ev[cyc_n] ? 128'(ex[cyc_n]) : 128'(0));
            check("err", 128'(err), 128'(0));
        end
        @(posedge clk);
        if (rst) begin
            m_st = 0;
            m_last = NR - 1;
            m_drained = 1'b0;
            p_dvld = 1'b0;
            p_b = '0;
            p_rnd = '0;
            for (int c = cyc_n + 1; c < NC; c++) ev[c] = 1'b0;
        end else begin
            p_dvld = w >= 0;
            p_b = (w >= 0) ? req_b[w*MW +: MW] : '0;
            p_rnd = (w >= 0) ? rnd_in : '0;
            if (w >= 0) begin
                ev[cyc_n + LATC + 2] = 1'b1;
                eid[cyc_n + LATC + 2] = w;
                ex[cyc_n + LATC + 2] = bxor(req_b[w*MW +: MW]);
                m_last = w;
            end
            m_drained = m_st == 2 && !pipe;
            m_st = (m_st == 0) ? (en ? 1 : 0) : (m_st == 1) ? ((drain || !en) ? 2 : 1) : (pipe ? 2 : 0);
        end
        cyc_n++;
        if (cyc_n + LATC + 3 >= NC) begin
            $display("FAIL cycle_budget: got %0d cycles expected under %0d", cyc_n, NC - LATC - 3);
            $fatal(1);
        end
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] rv, input logic rn);
        req_vld = rv;
        rnd_vld = rn;
        for (int i = 0; i < NR * NS; i++) req_b[i*KW +: KW] = $urandom;
        rnd_word = $urandom;
        rnd_in = {(RW/KW){rnd_word}};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        drain = 1'b0;
        drive('0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic single_job();
        int hs, got;
        logic [KW-1:0] s0, s1;
        en = 1'b1;
        drive('0, 1'b1);
        cyc();
        drive(2'b01, 1'b1);
        s0 = $urandom;
        s1 = $urandom;
        req_b[0 +: MW] = {32'h1234_5678 ^ s0 ^ s1, s1, s0};
        hs = cyc_n;
        cyc();
        check("sj_handshake", 128'(obs_rdy), 128'(2'b01));
        drive('0, 1'b1);
        got = -1;
        for (int i = 0; i < LATC + 4; i++) begin
            cyc();
            if (obs_res != '0 && got < 0) begin
                got = cyc_n - 1 - hs;
                check("sj_res_vld", 128'(obs_res), 128'(2'b01));
                check("sj_sum", 128'(obs_sum), 128'(32'h1234_5678));
            end
        end
        check("sj_latency", 128'(got), 128'(LATC + 2));
    endtask

    initial begin
        int n_rdy, n_res, n_pulse;
        logic busy_at_pulse;
        tbl[0] = '{2'b11, 1'b1, 2'b01};
        tbl[1] = '{2'b11, 1'b1, 2'b10};
        tbl[2] = '{2'b11, 1'b0, 2'b00};
        tbl[3] = '{2'b10, 1'b1, 2'b10};
        tbl[4] = '{2'b10, 1'b1, 2'b10};
        tbl[5] = '{2'b01, 1'b1, 2'b01};
        tbl[6] = '{2'b11, 1'b1, 2'b10};
        tbl[7] = '{2'b00, 1'b1, 2'b00};
        tbl[8] = '{2'b11, 1'b1, 2'b01};
        tbl[9] = '{2'b01, 1'b0, 2'b00};

        @(posedge clk);
        #1;
        chk = 1'b1;
        do_reset();
        cyc();
        check("reset_all_zero", 128'(obs_any), 128'(0));

        single_job();

        do_reset();
        en = 1'b1;
        drive('0, 1'b1);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rv, tbl[i].rn);
            cyc();
            check("arb_tbl", 128'(obs_rdy), 128'(tbl[i].exp_rdy));
        end

        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 1'b1);
            cyc();
            check("contention", 128'(obs_rdy), (i % 2 == 0) ? 128'(2'b10) : 128'(2'b01));
        end

        for (int i = 0; i < 4; i++) begin
            drive(2'b11, (i % 2 == 0));
            cyc();
            check("starve_rnd_rdy", 128'(obs_rnd_rdy), 128'(i % 2 == 0));
        end
        drive('0, 1'b0);
        for (int i = 0; i < LATC + 3; i++) cyc();

        for (int i = 0; i < 300; i++) begin
            en = ($urandom % 20) != 0;
            drain = ($urandom % 25) == 0;
            drive(NR'($urandom), ($urandom % 4) != 0);
            cyc();
        end
        drain = 1'b0;

        do_reset();
        en = 1'b1;
        drive('0, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'b1);
            cyc();
        end
        drain = 1'b1;
        en = 1'b0;
        drive(2'b11, 1'b1);
        cyc();
        check("drain_same_cycle_issue", 128'(obs_rdy), 128'(2'b10));
        n_rdy = 0;
        n_res = 0;
        n_pulse = 0;
        busy_at_pulse = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(2'b11, 1'b1);
            cyc();
            if (obs_rdy != '0) n_rdy++;
            if (obs_res != '0) n_res++;
            if (obs_drained) begin
                n_pulse++;
                busy_at_pulse = obs_busy;
            end
        end
        check("drain_no_rdy", 128'(n_rdy), 128'(0));
        check("drain_results", 128'(n_res), 128'(4));
        check("drain_pulses", 128'(n_pulse), 128'(1));
        check("drain_busy_at_pulse", 128'(busy_at_pulse), 128'(0));
        drain = 1'b0;

        do_reset();
        en = 1'b1;
        drive('0, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b1);
            cyc();
        end
        drive('0, 1'b1);
        cyc();
        rst = 1'b1;
        en = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("midrst_all_zero", 128'(obs_any), 128'(0));
        n_res = 0;
        for (int i = 0; i < LATC + 6; i++) begin
            cyc();
            if (obs_res != '0) n_res++;
        end
        check("midrst_no_results", 128'(n_res), 128'(0));
        single_job();

`ifdef B2A_SCHED_LATCHK_EN
        do_reset();
        chk = 1'b0;
        early = 1'b1;
        single_job();
        check("latchk_err_set", 128'(obs_err), 128'(1));
        drive('0, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        check("latchk_err_sticky", 128'(obs_err), 128'(1));
        early = 1'b0;
        do_reset();
        cyc();
        check("latchk_err_cleared", 128'(obs_err), 128'(0));
        chk = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000 time units");
        $fatal(1);
    end
endmodule
